// File: rtl/sh_packet_io.sv
// rtl/sh_packet_io.sv - bit-level RX assembler / TX serialiser driven by S/H sync strobes
//
// Purpose:
//   Sits directly downstream of the S/H sync FSM.
//   RX mode: after an fsm_rst alignment pulse, discards SKIP_FIRST strobes, then
//   samples data_in on each sh_en. It assembles a PACKET_SIZE word, first bit in the
//   MSB, and offers the word on a valid/ready handshake.
//   TX mode: latches a word and shifts {PREAMBLE_PATTERN, word} MSB first onto
//   tx_bit, one bit per sh_en.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   RX                  mode select: 1 = receive, 0 = transmit
//   sh_en               one-cycle bit strobe
//   fsm_rst             RX alignment restart pulse
//   data_in             sliced RX bit
//   rx_data/rx_valid    received word, held until rx_ready
//   rx_ready            consumer accepts rx_data
//   rx_overrun          pulse: a word completed while the previous one was unaccepted
//   tx_data/tx_load     word to send / latch strobe (honoured when idle in TX mode)
//   tx_busy             TX word latched or in flight
//   tx_bit              registered serial TX bit
//   tx_done             pulse one cycle after the last TX bit is issued
module sh_packet_io #(
  parameter int                       PACKET_SIZE      = 24,
  parameter int                       PREAMBLE_SIZE    = 8,
  parameter logic [PREAMBLE_SIZE-1:0] PREAMBLE_PATTERN = 8'hAA,
  parameter int                       SKIP_FIRST       = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   RX,
  input  logic                   sh_en,
  input  logic                   fsm_rst,
  input  logic                   data_in,
  output logic [PACKET_SIZE-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   rx_overrun,
  input  logic [PACKET_SIZE-1:0] tx_data,
  input  logic                   tx_load,
  output logic                   tx_busy,
  output logic                   tx_bit,
  output logic                   tx_done
);

  localparam int         TX_BITS   = PREAMBLE_SIZE + PACKET_SIZE;
  localparam logic [5:0] RX_LAST   = 6'(PACKET_SIZE - 1);
  localparam logic [5:0] TX_END    = 6'(TX_BITS);
  localparam logic [5:0] SKIP_INIT = 6'(SKIP_FIRST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_ALIGN,
    S_RX_SHIFT,
    S_TX_ARMED,
    S_TX_SEND
  } state_e;

  state_e                 state_q, state_d;
  logic [5:0]             skip_q, skip_d;
  logic [5:0]             bit_cnt_q, bit_cnt_d;
  logic [PACKET_SIZE-1:0] rx_shift_q, rx_shift_d;
  logic [PACKET_SIZE-1:0] rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_overrun_q, rx_overrun_d;
  logic [TX_BITS-1:0]     tx_shift_q, tx_shift_d;
  logic                   tx_busy_q, tx_busy_d;
  logic                   tx_bit_q, tx_bit_d;
  logic                   tx_done_q, tx_done_d;

  // Word as it stands once the current data_in is shifted in.
  logic [PACKET_SIZE-1:0] rx_word_next;
  assign rx_word_next = {rx_shift_q[PACKET_SIZE-2:0], data_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      skip_q       <= '0;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      tx_shift_q   <= '0;
      tx_busy_q    <= 1'b0;
      tx_bit_q     <= 1'b0;
      tx_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      skip_q       <= skip_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      tx_shift_q   <= tx_shift_d;
      tx_busy_q    <= tx_busy_d;
      tx_bit_q     <= tx_bit_d;
      tx_done_q    <= tx_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    skip_d       = skip_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    // The output handshake runs regardless of state or mode.
    rx_valid_d   = rx_valid_q & ~rx_ready;
    rx_overrun_d = 1'b0;
    tx_shift_d   = tx_shift_q;
    tx_busy_d    = tx_busy_q;
    tx_bit_d     = tx_bit_q;
    tx_done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (RX && fsm_rst) begin
          skip_d     = SKIP_INIT;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          state_d    = (SKIP_FIRST == 0) ? S_RX_SHIFT : S_RX_ALIGN;
        end else if (!RX && tx_load) begin
          tx_shift_d = {PREAMBLE_PATTERN, tx_data};
          bit_cnt_d  = '0;
          tx_busy_d  = 1'b1;
          state_d    = S_TX_ARMED;
        end
      end

      S_RX_ALIGN, S_RX_SHIFT: begin
        if (!RX) begin
          // Mode change drops the partial word silently.
          bit_cnt_d = '0;
          state_d   = S_IDLE;
        end else if (fsm_rst) begin
          // A new preamble edge takes priority over a coincident strobe.
          skip_d     = SKIP_INIT;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          state_d    = (SKIP_FIRST == 0) ? S_RX_SHIFT : S_RX_ALIGN;
        end else if (sh_en) begin
          if (state_q == S_RX_ALIGN) begin
            skip_d = skip_q - 6'd1;
            if (skip_q == 6'd1) begin
              state_d = S_RX_SHIFT;
            end
          end else begin
            rx_shift_d = rx_word_next;
            bit_cnt_d  = bit_cnt_q + 6'd1;
            if (bit_cnt_q == RX_LAST) begin
              bit_cnt_d = '0;
              state_d   = S_IDLE;
              if (rx_valid_q && !rx_ready) begin
                // Previous word still pending: keep it, drop the new one.
                rx_overrun_d = 1'b1;
              end else begin
                rx_data_d  = rx_word_next;
                rx_valid_d = 1'b1;
              end
            end
          end
        end
      end

      S_TX_ARMED, S_TX_SEND: begin
        if (RX) begin
          tx_busy_d = 1'b0;
          tx_bit_d  = 1'b0;
          bit_cnt_d = '0;
          state_d   = S_IDLE;
        end else if (bit_cnt_q == TX_END) begin
          // Last bit has had its cycle on tx_bit; finish up.
          tx_done_d = 1'b1;
          tx_busy_d = 1'b0;
          tx_bit_d  = 1'b0;
          bit_cnt_d = '0;
          state_d   = S_IDLE;
        end else if (sh_en) begin
          tx_bit_d   = tx_shift_q[TX_BITS-1];
          tx_shift_d = {tx_shift_q[TX_BITS-2:0], 1'b0};
          bit_cnt_d  = bit_cnt_q + 6'd1;
          state_d    = S_TX_SEND;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_overrun_q;
  assign tx_busy    = tx_busy_q;
  assign tx_bit     = tx_bit_q;
  assign tx_done    = tx_done_q;

endmodule

// File: tb/tb_sh_packet_io.sv
// tb/tb_sh_packet_io.sv - scoreboard bench for sh_packet_io
`timescale 1ns/1ps
module tb_sh_packet_io;

  localparam int         PS   = 24;
  localparam int         PRE  = 8;
  localparam int         SKIP = 1;
  localparam logic [7:0] PAT  = 8'hAA;

  localparam int K_RST    = 0;
  localparam int K_RXWORD = 1;
  localparam int K_RXV0   = 2;
  localparam int K_OVR    = 3;
  localparam int K_TXBIT  = 4;
  localparam int K_TXDONE = 5;
  localparam int K_ABORT  = 6;
  localparam int K_BUSY   = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          RX = 1'b0;
  logic          sh_en = 1'b0;
  logic          fsm_rst = 1'b0;
  logic          data_in = 1'b0;
  logic          rx_ready = 1'b1;
  logic          tx_load = 1'b0;
  logic [PS-1:0] tx_data = '0;
  logic [PS-1:0] rx_data;
  logic          rx_valid, rx_overrun, tx_busy, tx_bit, tx_done;

  always #50 clk = ~clk;

  sh_packet_io #(
    .PACKET_SIZE(PS), .PREAMBLE_SIZE(PRE), .PREAMBLE_PATTERN(PAT), .SKIP_FIRST(SKIP)
  ) dut (
    .clk(clk), .rst(rst), .RX(RX), .sh_en(sh_en), .fsm_rst(fsm_rst), .data_in(data_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun),
    .tx_data(tx_data), .tx_load(tx_load), .tx_busy(tx_busy), .tx_bit(tx_bit), .tx_done(tx_done)
  );

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
  } ev_t;

  ev_t evq[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int c, input int k, input logic [31:0] v);
    evq.push_back('{cyc: c, kind: k, val: v});
  endfunction

  // Monitor: counts output pulses and checks each expected event at its cycle.
  int   cnt_done = 0;
  int   cnt_ovr  = 0;
  int   cnt_rise = 0;
  logic prev_v   = 1'b0;

  always @(negedge clk) begin : mon
    ev_t e;
    if (tx_done === 1'b1) cnt_done++;
    if (rx_overrun === 1'b1) cnt_ovr++;
    if (rx_valid === 1'b1 && !prev_v) cnt_rise++;
    prev_v = (rx_valid === 1'b1);
    while (evq.size() > 0 && evq[0].cyc <= cyc) begin
      e = evq.pop_front();
      if (e.cyc < cyc) begin
        chk("event_late", 32'(cyc), 32'(e.cyc));
      end else begin
        case (e.kind)
          K_RST:    chk("reset_outputs", 32'({rx_data, rx_valid, rx_overrun, tx_busy, tx_bit, tx_done}), 32'd0);
          K_RXWORD: chk("rx_word", 32'({rx_valid, rx_data}), 32'({1'b1, e.val[PS-1:0]}));
          K_RXV0:   chk("rx_valid_clear", 32'(rx_valid), 32'd0);
          K_OVR:    chk("rx_overrun", 32'(rx_overrun), 32'd1);
          K_TXBIT:  chk("tx_bit", 32'({tx_busy, tx_bit, tx_done}), 32'({1'b1, e.val[0], 1'b0}));
          K_TXDONE: chk("tx_done", 32'({tx_busy, tx_bit, tx_done}), 32'd1);
          K_ABORT:  chk("tx_abort", 32'({tx_busy, tx_bit, tx_done}), 32'd0);
          K_BUSY:   chk("tx_busy", 32'(tx_busy), 32'(e.val[0]));
          default:  chk("event_kind", 32'(e.kind), 32'd0);
        endcase
      end
    end
  end

  // Reference model state
  bit            m_rx_act = 1'b0;
  int            m_skip   = 0;
  int            m_n      = 0;
  logic [PS-1:0] m_word   = '0;
  bit            m_held   = 1'b0;
  int            m_held_cyc = 0;
  logic [PS-1:0] m_held_word = '0;
  bit            m_tx_busy = 1'b0;
  bit            m_txq[$];
  int            exp_done = 0;
  int            exp_ovr  = 0;
  int            exp_rise = 0;

  task automatic tick();
    if (m_held && m_held_cyc <= cyc && rx_ready) m_held = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  function automatic void rx_restart();
    m_rx_act = 1'b1;
    m_skip   = SKIP;
    m_n      = 0;
    m_word   = '0;
  endfunction

  function automatic void rx_complete(input logic [PS-1:0] w);
    if (m_held && !rx_ready) begin
      exp_ovr++;
      push(cyc + 1, K_OVR, 0);
      push(cyc + 1, K_RXWORD, 32'(m_held_word));
    end else begin
      if (!m_held) exp_rise++;
      m_held      = 1'b1;
      m_held_cyc  = cyc + 1;
      m_held_word = w;
      push(cyc + 1, K_RXWORD, 32'(w));
    end
  endfunction

  task automatic strobe(input logic b, input bit f = 1'b0);
    int   gap;
    logic tb_b;
    gap     = $urandom_range(2, 6);
    sh_en   = 1'b1;
    data_in = b;
    fsm_rst = f;
    if (RX) begin
      if (f) begin
        rx_restart();
      end else if (m_rx_act) begin
        if (m_skip > 0) begin
          m_skip--;
        end else begin
          m_word = {m_word[PS-2:0], b};
          m_n++;
          if (m_n == PS) begin
            m_rx_act = 1'b0;
            rx_complete(m_word);
          end
        end
      end
    end else if (m_txq.size() > 0) begin
      tb_b = m_txq.pop_front();
      push(cyc + 1, K_TXBIT, 32'(tb_b));
      if (m_txq.size() == 0) begin
        push(cyc + 2, K_TXDONE, 0);
        exp_done++;
        m_tx_busy = 1'b0;
      end else begin
        push(cyc + 2, K_TXBIT, 32'(tb_b));
      end
    end
    tick();
    sh_en   = 1'b0;
    fsm_rst = 1'b0;
    data_in = 1'($urandom);
    idle(gap - 1);
  endtask

  task automatic pulse_fsm_rst();
    fsm_rst = 1'b1;
    if (RX) rx_restart();
    tick();
    fsm_rst = 1'b0;
    idle(1);
  endtask

  task automatic set_rx(input logic m);
    RX = m;
    if (m && m_tx_busy) begin
      m_txq.delete();
      m_tx_busy = 1'b0;
      push(cyc + 1, K_ABORT, 0);
    end
    if (!m) m_rx_act = 1'b0;
    tick();
    idle(1);
  endtask

  task automatic load_tx(input logic [PS-1:0] w);
    tx_data = w;
    tx_load = 1'b1;
    if (!RX && !m_tx_busy) begin
      m_txq.delete();
      for (int i = PRE - 1; i >= 0; i--) m_txq.push_back(PAT[i]);
      for (int i = PS - 1; i >= 0; i--) m_txq.push_back(w[i]);
      m_tx_busy = 1'b1;
    end
    push(cyc + 1, K_BUSY, 32'(m_tx_busy));
    tick();
    tx_load = 1'b0;
    tx_data = PS'($urandom);
    idle(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_rx_act  = 1'b0;
    m_held    = 1'b0;
    m_txq.delete();
    m_tx_busy = 1'b0;
    push(cyc + 1, K_RST, 0);
    tick();
    rst = 1'b0;
    idle(1);
  endtask

  task automatic rx_bits(input logic [PS-1:0] w);
    strobe(1'($urandom));
    for (int i = PS - 1; i >= 0; i--) strobe(w[i]);
  endtask

  task automatic rx_packet(input logic [PS-1:0] w);
    pulse_fsm_rst();
    rx_bits(w);
  endtask

  task automatic tx_packet(input logic [PS-1:0] w);
    load_tx(w);
    repeat (PRE + PS) strobe(1'($urandom));
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    push(cyc, K_RST, 0);
    idle(2);

    // T1: basic receive
    set_rx(1'b1);
    rx_packet(24'hA5C3F0);
    idle(3);

    // T2: consumer stalls, second word overruns, then accept
    rx_ready = 1'b0;
    rx_packet(24'hA5C3F0);
    rx_packet(24'h0F0F0F);
    idle(3);
    rx_ready = 1'b1;
    push(cyc + 1, K_RXV0, 0);
    tick();
    idle(2);

    // T3: alignment restart coincident with a strobe
    pulse_fsm_rst();
    repeat (10) strobe(1'($urandom));
    strobe(1'($urandom), 1'b1);
    rx_bits(24'h123456);
    idle(3);

    // RX drops mid-word: partial discarded, strobes without realignment ignored
    pulse_fsm_rst();
    repeat (8) strobe(1'($urandom));
    set_rx(1'b0);
    set_rx(1'b1);
    repeat (5) strobe(1'($urandom));
    rx_packet(PS'($urandom));

    // T4: basic transmit
    set_rx(1'b0);
    tx_packet(24'hDEAD01);
    idle(3);

    // T5: load while busy ignored, then abort by RX
    load_tx(PS'($urandom));
    repeat (6) strobe(1'($urandom));
    load_tx(24'h000000);
    repeat (6) strobe(1'($urandom));
    set_rx(1'b1);
    idle(2);
    set_rx(1'b0);
    tx_packet(PS'($urandom));

    // T6: reset mid RX_SHIFT and mid TX_SEND
    set_rx(1'b1);
    pulse_fsm_rst();
    repeat (10) strobe(1'($urandom));
    do_reset();
    rx_packet(PS'($urandom));
    set_rx(1'b0);
    load_tx(PS'($urandom));
    repeat (15) strobe(1'($urandom));
    do_reset();
    tx_packet(PS'($urandom));

    // Random mix
    repeat (6) begin
      if ($urandom_range(0, 1) == 1) begin
        set_rx(1'b1);
        rx_packet(PS'($urandom));
      end else begin
        set_rx(1'b0);
        tx_packet(PS'($urandom));
      end
    end

    idle(10);
    chk("tx_done_pulses", 32'(cnt_done), 32'(exp_done));
    chk("rx_overrun_pulses", 32'(cnt_ovr), 32'(exp_ovr));
    chk("rx_valid_rises", 32'(cnt_rise), 32'(exp_rise));
    chk("events_pending", 32'(evq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
